// File: rtl/busifc_alu_if.sv
// Transaction bus for busifc_alu: valid-qualified opcode/operand request,
// registered result response one cycle later.
interface busifc_alu_if;
    logic              in_valid;
    logic [1:0]        opcode;
    logic signed [7:0] operand1;
    logic signed [7:0] operand2;
    logic              out_valid;
    logic signed [15:0] result;
    logic              div_by_zero;

    modport master (
        output in_valid, opcode, operand1, operand2,
        input  out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, opcode, operand1, operand2,
        output out_valid, result, div_by_zero
    );
endinterface

// File: rtl/busifc_alu.sv
// Signed 8-bit ALU bus slave with one-cycle registered result and sticky
// per-opcode / opcode x operand1-corner coverage bits.
module busifc_alu (
    input  logic          gclk,
    input  logic          grst_n,
    busifc_alu_if.slave   bus,
    input  logic          cov_clear,
    output logic [3:0]    cov_op,
    output logic [11:0]   cov_cross,
    output logic          cov_done
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MULT = 2'd2,
        OP_DIV  = 2'd3
    } op_e;

    typedef struct packed {
        logic signed [15:0] res;
        logic               dbz;
    } rsp_t;

    op_e                op;
    logic signed [15:0] a_ext;
    logic signed [15:0] b_ext;
    rsp_t               alu;

    assign op    = op_e'(bus.opcode);
    assign a_ext = {{8{bus.operand1[7]}}, bus.operand1};
    assign b_ext = {{8{bus.operand2[7]}}, bus.operand2};

    // 16-bit operands make every result fit exactly, including -128/-1 = +128.
    always_comb begin
        alu.res = '0;
        alu.dbz = 1'b0;
        case (op)
            OP_ADD:  alu.res = a_ext + b_ext;
            OP_SUB:  alu.res = a_ext - b_ext;
            OP_MULT: alu.res = a_ext * b_ext;
            OP_DIV: begin
                if (b_ext == 16'sd0) begin
                    alu.dbz = 1'b1;
                end else begin
                    alu.res = a_ext / b_ext;
                end
            end
            default: alu.res = '0;
        endcase
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            bus.out_valid   <= 1'b0;
            bus.result      <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result      <= alu.res;
                bus.div_by_zero <= alu.dbz;
            end
        end
    end

    logic [2:0]  corner_oh;
    logic [3:0]  op_hit;
    logic [11:0] cross_hit;

    assign corner_oh = {bus.operand1 == 8'sh7F,
                        bus.operand1 == 8'sh00,
                        bus.operand1 == -8'sd128};

    always_comb begin
        op_hit    = '0;
        cross_hit = '0;
        for (int g = 0; g < 4; g++) begin
            op_hit[g]          = bus.in_valid && (bus.opcode == 2'(g));
            cross_hit[g*3 +: 3] = op_hit[g] ? corner_oh : 3'b000;
        end
    end

    // Clear lands first so a transaction in the clear cycle is still recorded.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cov_op    <= '0;
            cov_cross <= '0;
        end else begin
            cov_op    <= (cov_clear ? 4'h0  : cov_op)    | op_hit;
            cov_cross <= (cov_clear ? 12'h0 : cov_cross) | cross_hit;
        end
    end

    assign cov_done = (cov_op == 4'hF) && (cov_cross == 12'hFFF);

endmodule

// File: tb/tb_busifc_alu.sv
// Directed bench for busifc_alu: hand-computed vectors, inputs driven on the
// falling edge, outputs sampled on the following falling edge.
module tb_busifc_alu;

    logic        gclk = 1'b0;
    logic        grst_n;
    logic        cov_clear;
    logic [3:0]  cov_op;
    logic [11:0] cov_cross;
    logic        cov_done;

    busifc_alu_if bus ();

    busifc_alu dut (
        .gclk      (gclk),
        .grst_n    (grst_n),
        .bus       (bus.slave),
        .cov_clear (cov_clear),
        .cov_op    (cov_op),
        .cov_cross (cov_cross),
        .cov_done  (cov_done)
    );

    always #50 gclk = ~gclk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.operand1 = a;
        bus.operand2 = b;
    endtask

    task automatic step();
        @(negedge gclk);
    endtask

    task automatic rsp(input string tag, input logic [15:0] res, input logic dbz);
        chk({tag, "_vld"}, 16'(bus.out_valid), 16'd1);
        chk({tag, "_res"}, bus.result, res);
        chk({tag, "_dbz"}, 16'(bus.div_by_zero), 16'(dbz));
    endtask

    logic [7:0]  corner_v [3];
    logic [15:0] exp_tbl  [12];

    initial begin
        corner_v = '{8'h80, 8'h00, 8'h7F};
        // operand2 = 3 across ADD, SUB, MULT, DIV for operand1 = -128, 0, 127
        exp_tbl  = '{16'hFF83, 16'h0003, 16'h0082,
                     16'hFF7D, 16'hFFFD, 16'h007C,
                     16'hFE80, 16'h0000, 16'h017D,
                     16'hFFD6, 16'h0000, 16'h002A};

        grst_n       = 1'b0;
        cov_clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.opcode   = 2'd0;
        bus.operand1 = 8'h00;
        bus.operand2 = 8'h00;
        #20;
        chk("rst_vld",   16'(bus.out_valid), 16'd0);
        chk("rst_res",   bus.result, 16'h0000);
        chk("rst_dbz",   16'(bus.div_by_zero), 16'd0);
        chk("rst_cov_op", 16'(cov_op), 16'h0);
        chk("rst_cross", 16'(cov_cross), 16'h000);
        chk("rst_done",  16'(cov_done), 16'd0);
        step();
        grst_n = 1'b1;
        step();

        drive(2'd0, 8'd5, 8'd3);      step(); rsp("add_5_3", 16'd8, 1'b0);
        chk("add_cov_op", 16'(cov_op), 16'h1);
        chk("add_cross", 16'(cov_cross), 16'h000);
        drive(2'd2, 8'h80, 8'h80);    step(); rsp("mul_min_min", 16'h4000, 1'b0);
        chk("mul_cross", 16'(cov_cross), 16'h040);
        drive(2'd1, 8'h80, 8'h7F);    step(); rsp("sub_min_max", 16'hFF01, 1'b0);
        drive(2'd3, 8'hF9, 8'd2);     step(); rsp("div_m7_2", 16'hFFFD, 1'b0);
        drive(2'd3, 8'd10, 8'd0);     step(); rsp("div_by0", 16'h0000, 1'b1);
        drive(2'd0, 8'd1, 8'd1);      step(); rsp("add_1_1", 16'h0002, 1'b0);
        drive(2'd3, 8'h80, 8'hFF);    step(); rsp("div_min_m1", 16'h0080, 1'b0);
        drive(2'd2, 8'h80, 8'h7F);    step(); rsp("mul_min_max", 16'hC080, 1'b0);
        drive(2'd0, 8'h80, 8'h80);    step(); rsp("add_min_min", 16'hFF00, 1'b0);
        drive(2'd1, 8'h7F, 8'h80);    step(); rsp("sub_max_min", 16'h00FF, 1'b0);

        bus.in_valid = 1'b0;          step();
        chk("idle_vld", 16'(bus.out_valid), 16'd0);
        chk("idle_hold", bus.result, 16'h00FF);

        cov_clear = 1'b1;             step();
        cov_clear = 1'b0;
        chk("clr_cov_op", 16'(cov_op), 16'h0);
        chk("clr_cross", 16'(cov_cross), 16'h000);

        for (int op = 0; op < 4; op++) begin
            for (int c = 0; c < 3; c++) begin
                drive(2'(op), corner_v[c], 8'd3);
                step();
                rsp($sformatf("b2b_%0d_%0d", op, c), exp_tbl[op*3+c], 1'b0);
                if (op == 3 && c == 1) begin
                    chk("b2b_cross_11", 16'(cov_cross), 16'h7FF);
                    chk("b2b_done_11", 16'(cov_done), 16'd0);
                end
            end
        end
        chk("b2b_cov_op", 16'(cov_op), 16'hF);
        chk("b2b_cross", 16'(cov_cross), 16'hFFF);
        chk("b2b_done", 16'(cov_done), 16'd1);

        drive(2'd0, 8'd5, 8'd0);      step(); rsp("noncorner", 16'h0005, 1'b0);
        chk("noncorner_cross", 16'(cov_cross), 16'hFFF);

        cov_clear = 1'b1;
        drive(2'd1, 8'h00, 8'd1);     step(); rsp("clr_sub", 16'hFFFF, 1'b0);
        cov_clear = 1'b0;
        chk("clrv_cov_op", 16'(cov_op), 16'h2);
        chk("clrv_cross", 16'(cov_cross), 16'h010);
        chk("clrv_done", 16'(cov_done), 16'd0);

        drive(2'd2, 8'd2, 8'd2);      step(); rsp("pre_rst", 16'h0004, 1'b0);
        #10 grst_n = 1'b0;
        #5;
        chk("mid_rst_vld", 16'(bus.out_valid), 16'd0);
        chk("mid_rst_res", bus.result, 16'h0000);
        chk("mid_rst_cov_op", 16'(cov_op), 16'h0);
        chk("mid_rst_cross", 16'(cov_cross), 16'h000);
        bus.in_valid = 1'b0;
        step();
        grst_n = 1'b1;
        drive(2'd2, 8'd3, 8'hFC);     step(); rsp("mul_3_m4", 16'hFFF4, 1'b0);
        chk("post_rst_cov_op", 16'(cov_op), 16'h4);

        bus.in_valid = 1'b0;          step();
        chk("end_vld", 16'(bus.out_valid), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
